// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the TX path and the future RX block.
//   tx_state_e  : transmitter FSM states
//   FRAME_BITS  : start + 8 data + stop bits per 8N1 frame
//   baud_div()  : clocks per bit, truncating integer divide
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int FRAME_BITS = 10;

   // Clocks per bit; callers must keep the result >= 2.
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Free-running bit-period counter, 0..DIV-1, reusable by TX and RX.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   clear     : hold the counter at 0 (owner is idle)
//   tick      : high while the counter equals DIV-1 (last clock of a bit)
//   tick_next : high while the counter equals DIV-2 (tick follows next clock)
// -----------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic tick_next
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(DIV - 2);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick      = (cnt_q == LAST);
   assign tick_next = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// 8N1 UART transmitter draining bytes from a FIFO read port.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_rdata : FIFO head byte, valid while fifo_empty = 0
//   fifo_rd    : FIFO pop strobe (combinational, only in IDLE)
//   tx         : serial line, idle high (registered)
//   tx_busy    : frame in flight (registered)
//   tx_done    : one-cycle pulse in the last clock of the stop bit (registered)
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); CLK_FREQ/BAUD must be >= 2.
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD);

   tx_state_e  state_q,   state_d;
   logic [7:0] shift_q,   shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       tx_q,      tx_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;

   logic       baud_clear;
   logic       tick;
   logic       tick_next;
   logic       pop;

   // Gated with rst so no pop can be requested while the block is held in reset.
   assign pop        = (state_q == IDLE) && !fifo_empty && rst;
   assign fifo_rd    = pop;
   assign baud_clear = (state_q == IDLE);

   baud_tick_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .clear     (baud_clear),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (pop) begin
               shift_d   = fifo_rdata;
               bit_idx_d = 3'd0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               state_d   = START;
            end
         end

         START: begin
            if (tick) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end

         DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // tx is registered, so it picks up the bit that becomes LSB after this shift.
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end

         STOP: begin
            // Register one clock early so tx_done lands on the final stop-bit clock.
            done_d = tick_next;
            if (tick) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         bit_idx_q <= 3'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

   a_no_pop_in_frame : assert property (@(posedge clk) disable iff (!rst)
      fifo_rd |-> !tx_busy);
   a_done_in_stop    : assert property (@(posedge clk) disable iff (!rst)
      tx_done |-> (tx_busy && (state_q == STOP)));

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains bytes from the 8-entry FIFO's read port (`rd`/`rdata`/`empty`) and serialises them onto a single TX line as 8N1 frames. It is the reader end of the FIFO in the RX → FIFO → TX loopback path: it pops one byte whenever it is idle and the FIFO is non-empty, then shifts it out LSB first at the configured baud rate.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line bit rate; `DIV = CLK_FREQ / BAUD` clocks per bit (integer divide, truncating), `DIV >= 2` required
---
- `clk`  input  1  system clock, all state updates on the rising edge
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low
- `fifo_empty`  input  1  FIFO empty flag
- `fifo_rdata`  input  8  FIFO head byte, valid combinationally whenever `fifo_empty` = 0
- `fifo_rd`  output  1  FIFO pop strobe
- `tx`  output  1  serial line, idle high
- `tx_busy`  output  1  high while a frame is in flight (START/DATA/STOP)
- `tx_done`  output  1  one-cycle pulse at the end of each stop bit

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `tx` = 1. `fifo_rd` = (state == IDLE) & ~`fifo_empty`, combinational. On a clock edge with `fifo_rd` = 1: latch `fifo_rdata` into an 8-bit shift register, clear the baud counter and bit index, and go to START. The FIFO pops on the same edge.
- START: `tx` = 0 for DIV cycles, then go to DATA.
- DATA: `tx` = shift_reg[0]. Every DIV cycles, shift right and increment bit index. After the 8th bit, go to STOP. Bits go out LSB first.
- STOP: `tx` = 1 for DIV cycles. On the last cycle, assert `tx_done` and go to IDLE.
- Baud counter: width `$clog2(DIV)`. It counts 0..DIV-1 and wraps to 0 when a bit completes. It is held at 0 in IDLE.
- Bit index: 3 bits, 0..7. It does not wrap inside a frame.
- `fifo_rd` is never asserted outside IDLE. At most one pop per frame; a pop while empty is impossible by construction.
- `fifo_empty` rising mid-frame has no effect on the frame in flight.
- `tx`, `tx_busy` and `tx_done` are registered. `fifo_rd` is the only combinational output.

## Timing
- Reset (asserted, async): state = IDLE, `tx` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_rd` = 0, counters = 0, shift_reg = 0.
- Reset asserted mid-frame: the frame is aborted immediately and `tx` goes high asynchronously. The popped byte is lost and is not re-read.
- Pop at edge E:
  - `tx` falls and `tx_busy` rises at E.
  - Start bit spans E to E+DIV.
  - Data bit k spans E+(1+k)·DIV to E+(2+k)·DIV.
  - Stop bit spans E+9·DIV to E+10·DIV.
  - `tx_done` is high for the cycle ending at E+10·DIV. `tx_busy` falls at E+10·DIV.
- Frame length is exactly 10·DIV clocks.
- Back-to-back: if `fifo_empty` = 0 in the IDLE cycle after STOP, the next pop happens at E+10·DIV+1. The inter-frame gap is therefore exactly 1 clock of `tx` = 1.
- Simultaneous FIFO write and this block's pop: FIFO-side behaviour only. This block sees just `fifo_empty` and `fifo_rdata`.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e`
  - constant function `baud_div(clk_freq, baud)`
  - localparam `FRAME_BITS = 10`, shared with the future RX block.
- Sub-module `baud_tick_gen`:
  - parameter `DIV`
  - inputs `clk`, `rst`, `clear`
  - output `tick`, pulsing when the counter equals DIV-1
  - The FSM uses `clear` in IDLE. The same generator is intended for reuse by RX.
- Top: FSM, shift register, bit index and output registers in `fifo_uart_tx`.

## Test plan
Benches use `CLK_FREQ` = 1000 and `BAUD` = 100, so DIV = 10. A behavioural 8-deep FIFO model sits on the read port.
- **Reset:** hold `rst` = 0 for 3 cycles with FIFO empty → `tx` = 1, `tx_busy` = 0, `fifo_rd` = 0, `tx_done` = 0 throughout and after release.
- **Single byte:** push 0xA5 → exactly one `fifo_rd` pulse. `tx` samples at bit centres (E+5+10k) read 0,1,0,1,0,0,1,0,1,1. One `tx_done` pulse at E+99.
- **Back-to-back:** push 0x00, 0xFF, 0x3C → three frames. Each gap between a stop bit and the next start bit is exactly 1 cycle. The FIFO is empty after the third pop and `fifo_rd` never pulses while `fifo_empty` = 1.
- **Full FIFO drain:** push 8 bytes 0x01..0x08 (FIFO full) → 8 frames in order, decoded by the line monitor. Total time is 8·101 − 1 cycles from first pop to last `tx_done`.
- **Reset mid-frame:** assert `rst` during DATA bit 3 of 0x55 → `tx` = 1 immediately and state returns to IDLE. After release, the next queued byte 0x66 is sent as a complete, correct frame.
- **Late arrival:** FIFO empty for 50 cycles, then push 0x81 → `fifo_rd` asserts in the first cycle `fifo_empty` = 0. The frame decodes as 0x81.
